// File: rtl/ddr2_uart_cmd_ctrl.sv
// UART byte-frame command sequencer driving the DDR2 controller user port.
// Parses write/read frames, issues 4-word DDR2 bursts and streams read data to the UART TX.
module ddr2_uart_cmd_ctrl #(
   parameter int ADDR_WIDTH    = 26,
   parameter int DATA_WIDTH    = 32,
   parameter int PAYLOAD_WORDS = 4,
   parameter int TIMEOUT_CYC   = 1_000_000
) (
   input  logic                  sys_clk,
   input  logic                  sys_rst,
   input  logic [7:0]            rx_data,
   input  logic                  rx_valid,
   output logic [7:0]            tx_data,
   output logic                  tx_valid,
   input  logic                  tx_ready,
   input  logic                  init_end,
   output logic                  wr_req,
   input  logic                  wr_ack,
   output logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic                  wr_data_en,
   output logic [DATA_WIDTH-1:0] wr_data,
   output logic                  rd_req,
   input  logic                  rd_ack,
   output logic [ADDR_WIDTH-1:0] rd_addr,
   input  logic                  rd_data_valid,
   input  logic [DATA_WIDTH-1:0] rd_data,
   output logic                  busy,
   output logic                  wr_done,
   output logic                  rd_done,
   output logic                  frame_err
);

   localparam int BPW   = DATA_WIDTH / 8;
   localparam int BYTES = PAYLOAD_WORDS * BPW;
   localparam int CW    = $clog2(BYTES);
   localparam int WIW   = (PAYLOAD_WORDS > 1) ? $clog2(PAYLOAD_WORDS) : 1;
   localparam int GW    = $clog2(TIMEOUT_CYC + 1);

   typedef enum logic [3:0] {
      S_CMD, S_ADDR, S_DATA, S_TERM, S_WAIT_INIT,
      S_WR_REQ, S_WR_DATA, S_RD_REQ, S_RD_DATA, S_TX
   } state_t;

   state_t                            state_q, state_d;
   logic                              op_wr_q, op_wr_d;
   logic [ADDR_WIDTH-1:0]             addr_q, addr_d;
   logic [PAYLOAD_WORDS*DATA_WIDTH-1:0] payload_q, payload_d;
   logic [CW-1:0]                     byte_cnt_q, byte_cnt_d;
   logic [WIW-1:0]                    word_idx_q, word_idx_d;
   logic [GW-1:0]                     gap_q, gap_d;
   logic                              frame_err_q, frame_err_d;
   logic                              wr_done_q, wr_done_d;
   logic                              rd_done_q, rd_done_d;
   logic                              gap_hit;
   logic                              in_frame;
   logic                              last_word;

   assign in_frame  = (state_q == S_ADDR) || (state_q == S_DATA) || (state_q == S_TERM);
   assign gap_hit   = (gap_q == GW'(TIMEOUT_CYC - 1));
   assign last_word = (word_idx_q == WIW'(PAYLOAD_WORDS - 1));

   always_comb begin
      state_d     = state_q;
      op_wr_d     = op_wr_q;
      addr_d      = addr_q;
      payload_d   = payload_q;
      byte_cnt_d  = byte_cnt_q;
      word_idx_d  = word_idx_q;
      gap_d       = '0;
      frame_err_d = 1'b0;
      wr_done_d   = 1'b0;
      rd_done_d   = 1'b0;

      if (in_frame && !rx_valid)
         gap_d = gap_q + GW'(1);

      case (state_q)
         S_CMD: begin
            if (rx_valid) begin
               if (rx_data == 8'h01 || rx_data == 8'h02) begin
                  op_wr_d    = (rx_data == 8'h01);
                  byte_cnt_d = '0;
                  state_d    = S_ADDR;
               end else begin
                  frame_err_d = 1'b1;
               end
            end
         end
         S_ADDR: begin
            if (rx_valid) begin
               // Only the low ADDR_WIDTH bits of the 32-bit big-endian address survive the shift.
               addr_d = {addr_q[ADDR_WIDTH-9:0], rx_data};
               if (byte_cnt_q == CW'(3)) begin
                  byte_cnt_d = '0;
                  state_d    = op_wr_q ? S_DATA : S_TERM;
               end else begin
                  byte_cnt_d = byte_cnt_q + CW'(1);
               end
            end else if (gap_hit) begin
               frame_err_d = 1'b1;
               byte_cnt_d  = '0;
               gap_d       = '0;
               state_d     = S_CMD;
            end
         end
         S_DATA: begin
            if (rx_valid) begin
               payload_d[8*int'(byte_cnt_q) +: 8] = rx_data;
               if (byte_cnt_q == CW'(BYTES - 1)) begin
                  byte_cnt_d = '0;
                  state_d    = S_TERM;
               end else begin
                  byte_cnt_d = byte_cnt_q + CW'(1);
               end
            end else if (gap_hit) begin
               frame_err_d = 1'b1;
               byte_cnt_d  = '0;
               gap_d       = '0;
               state_d     = S_CMD;
            end
         end
         S_TERM: begin
            if (rx_valid) begin
               if (rx_data == 8'hFF) begin
                  state_d = S_WAIT_INIT;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = S_CMD;
               end
            end else if (gap_hit) begin
               frame_err_d = 1'b1;
               gap_d       = '0;
               state_d     = S_CMD;
            end
         end
         S_WAIT_INIT: begin
            if (init_end)
               state_d = op_wr_q ? S_WR_REQ : S_RD_REQ;
         end
         S_WR_REQ: begin
            if (wr_ack) begin
               word_idx_d = '0;
               state_d    = S_WR_DATA;
            end
         end
         S_WR_DATA: begin
            if (wr_data_en) begin
               word_idx_d = last_word ? '0 : word_idx_q + WIW'(1);
               if (last_word) begin
                  wr_done_d = 1'b1;
                  state_d   = S_CMD;
               end
            end
         end
         S_RD_REQ: begin
            if (rd_ack) begin
               word_idx_d = '0;
               state_d    = S_RD_DATA;
            end
         end
         S_RD_DATA: begin
            if (rd_data_valid) begin
               payload_d[DATA_WIDTH*int'(word_idx_q) +: DATA_WIDTH] = rd_data;
               word_idx_d = last_word ? '0 : word_idx_q + WIW'(1);
               if (last_word) begin
                  byte_cnt_d = '0;
                  state_d    = S_TX;
               end
            end
         end
         S_TX: begin
            if (tx_ready) begin
               if (byte_cnt_q == CW'(BYTES - 1)) begin
                  byte_cnt_d = '0;
                  rd_done_d  = 1'b1;
                  state_d    = S_CMD;
               end else begin
                  byte_cnt_d = byte_cnt_q + CW'(1);
               end
            end
         end
         default: state_d = S_CMD;
      endcase

      // Bytes arriving while the DDR2 transfer is in flight are dropped.
      if (rx_valid && !in_frame && state_q != S_CMD)
         frame_err_d = 1'b1;
   end

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state_q     <= S_CMD;
         op_wr_q     <= 1'b0;
         addr_q      <= '0;
         payload_q   <= '0;
         byte_cnt_q  <= '0;
         word_idx_q  <= '0;
         gap_q       <= '0;
         frame_err_q <= 1'b0;
         wr_done_q   <= 1'b0;
         rd_done_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         op_wr_q     <= op_wr_d;
         addr_q      <= addr_d;
         payload_q   <= payload_d;
         byte_cnt_q  <= byte_cnt_d;
         word_idx_q  <= word_idx_d;
         gap_q       <= gap_d;
         frame_err_q <= frame_err_d;
         wr_done_q   <= wr_done_d;
         rd_done_q   <= rd_done_d;
      end
   end

   assign busy      = (state_q != S_CMD);
   assign tx_valid  = (state_q == S_TX);
   assign wr_req    = (state_q == S_WR_REQ);
   assign rd_req    = (state_q == S_RD_REQ);
   assign wr_addr   = addr_q;
   assign rd_addr   = addr_q;
   assign wr_data   = payload_q[DATA_WIDTH*int'(word_idx_q) +: DATA_WIDTH];
   assign tx_data   = payload_q[8*int'(byte_cnt_q) +: 8];
   assign frame_err = frame_err_q;
   assign wr_done   = wr_done_q;
   assign rd_done   = rd_done_q;

endmodule

// File: tb/tb_ddr2_uart_cmd_ctrl.sv
// Directed bench for ddr2_uart_cmd_ctrl: write/read frames, framing errors, timeout,
// init_end gating, overrun and asynchronous reset.
module tb_ddr2_uart_cmd_ctrl;

   localparam int TO = 200;

   logic        sys_clk, sys_rst;
   logic [7:0]  rx_data, tx_data;
   logic        rx_valid, tx_valid, tx_ready, init_end;
   logic        wr_req, wr_ack, wr_data_en, rd_req, rd_ack, rd_data_valid;
   logic [25:0] wr_addr, rd_addr;
   logic [31:0] wr_data, rd_data;
   logic        busy, wr_done, rd_done, frame_err;

   int checks = 0;
   int errors = 0;

   logic [31:0] words_a [4] = '{32'h44332211, 32'h88776655, 32'hCCBBAA99, 32'h2211EEDD};
   logic [31:0] words_b [4] = '{32'h03020100, 32'h07060504, 32'h0B0A0908, 32'h0F0E0D0C};
   logic [7:0]  pay [16];

   ddr2_uart_cmd_ctrl #(
      .ADDR_WIDTH   (26),
      .DATA_WIDTH   (32),
      .PAYLOAD_WORDS(4),
      .TIMEOUT_CYC  (TO)
   ) dut (
      .sys_clk      (sys_clk),
      .sys_rst      (sys_rst),
      .rx_data      (rx_data),
      .rx_valid     (rx_valid),
      .tx_data      (tx_data),
      .tx_valid     (tx_valid),
      .tx_ready     (tx_ready),
      .init_end     (init_end),
      .wr_req       (wr_req),
      .wr_ack       (wr_ack),
      .wr_addr      (wr_addr),
      .wr_data_en   (wr_data_en),
      .wr_data      (wr_data),
      .rd_req       (rd_req),
      .rd_ack       (rd_ack),
      .rd_addr      (rd_addr),
      .rd_data_valid(rd_data_valid),
      .rd_data      (rd_data),
      .busy         (busy),
      .wr_done      (wr_done),
      .rd_done      (rd_done),
      .frame_err    (frame_err)
   );

   initial begin
      sys_clk = 1'b0;
      forever #5 sys_clk = ~sys_clk;
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      rx_data  = b;
      rx_valid = 1'b1;
      tick();
      rx_valid = 1'b0;
   endtask

   task automatic send_hdr(input logic [7:0] cmd, input logic [31:0] addr);
      send_byte(cmd);
      for (int i = 3; i >= 0; i--) send_byte(addr[8*i +: 8]);
   endtask

   task automatic load_pay(input logic [31:0] w0, input logic [31:0] w1,
                           input logic [31:0] w2, input logic [31:0] w3);
      logic [127:0] flat;
      flat = {w3, w2, w1, w0};
      for (int k = 0; k < 16; k++) pay[k] = flat[8*k +: 8];
   endtask

   task automatic send_pay();
      for (int k = 0; k < 16; k++) send_byte(pay[k]);
   endtask

   initial begin
      int n;
      int hits;
      sys_rst = 1'b1;
      rx_data = '0; rx_valid = 0; tx_ready = 0; init_end = 0;
      wr_ack = 0; wr_data_en = 0; rd_ack = 0; rd_data_valid = 0; rd_data = '0;
      repeat (3) tick();
      chk("rst_busy", busy, 0);
      chk("rst_outs", {tx_valid, wr_req, rd_req, wr_done, rd_done, frame_err}, 0);
      chk("rst_wr_data", wr_data, 0);
      chk("rst_wr_addr", wr_addr, 0);
      sys_rst = 1'b0;
      tick();

      // Write frame at address 0
      init_end = 1'b1;
      load_pay(words_a[0], words_a[1], words_a[2], words_a[3]);
      send_hdr(8'h01, 32'h0);
      send_pay();
      send_byte(8'hFF);
      chk("wr_req_1cyc_after_term", wr_req, 0);
      tick();
      chk("wr_req_2cyc_after_term", wr_req, 1);
      chk("wr_addr0", wr_addr, 0);
      tick(); tick();
      chk("wr_req_held", wr_req, 1);
      wr_ack = 1'b1;
      tick();
      wr_ack = 1'b0;
      chk("wr_req_drop", wr_req, 0);
      wr_data_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("wr_word%0d", i), wr_data, words_a[i]);
         if (i < 3) chk("wr_done_early", wr_done, 0);
         tick();
      end
      wr_data_en = 1'b0;
      chk("wr_done_pulse", wr_done, 1);
      chk("busy_after_wr", busy, 0);
      tick();
      chk("wr_done_1cyc", wr_done, 0);

      // Read frame, returns same words, TX with toggling ready
      send_hdr(8'h02, 32'h0);
      send_byte(8'hFF);
      tick();
      chk("rd_req", rd_req, 1);
      chk("rd_addr0", rd_addr, 0);
      rd_ack = 1'b1;
      tick();
      rd_ack = 1'b0;
      chk("rd_req_drop", rd_req, 0);
      for (int i = 0; i < 4; i++) begin
         rd_data = words_a[i];
         rd_data_valid = 1'b1;
         chk("tx_valid_early", tx_valid, 0);
         tick();
      end
      rd_data_valid = 1'b0;
      chk("tx_valid_rise", tx_valid, 1);
      n = 0;
      for (int c = 0; c < 100 && n < 16; c++) begin
         tx_ready = (c % 2 == 1);
         if (tx_ready && tx_valid) begin
            chk($sformatf("tx_byte%0d", n), tx_data, pay[n]);
            n++;
         end
         tick();
      end
      tx_ready = 1'b0;
      chk("tx_count", n, 16);
      chk("rd_done_pulse", rd_done, 1);
      chk("tx_valid_end", tx_valid, 0);
      tick();
      chk("rd_done_1cyc", rd_done, 0);
      chk("busy_after_rd", busy, 0);

      // Bad terminator
      send_hdr(8'h01, 32'h0);
      send_pay();
      send_byte(8'h00);
      chk("bad_term_err", frame_err, 1);
      chk("bad_term_idle", busy, 0);
      hits = 0;
      for (int i = 0; i < 5; i++) begin
         hits += wr_req;
         tick();
      end
      chk("bad_term_no_req", hits, 0);
      chk("frame_err_1cyc", frame_err, 0);

      // Valid frame held off by init_end, then overrun during S_WR_DATA
      init_end = 1'b0;
      load_pay(words_b[0], words_b[1], words_b[2], words_b[3]);
      send_hdr(8'h01, 32'hABCDEF12);
      send_pay();
      send_byte(8'hFF);
      hits = 0;
      for (int i = 0; i < 1000; i++) begin
         hits += (wr_req | rd_req);
         tick();
      end
      chk("no_req_wo_init", hits, 0);
      chk("busy_wait_init", busy, 1);
      init_end = 1'b1;
      tick();
      chk("wr_req_after_init", wr_req, 1);
      chk("wr_addr_masked", wr_addr, 26'h3CDEF12);
      wr_ack = 1'b1;
      tick();
      wr_ack = 1'b0;
      send_byte(8'h55);
      chk("overrun_err", frame_err, 1);
      chk("overrun_busy", busy, 1);
      chk("overrun_wr_data", wr_data, words_b[0]);
      wr_data_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("wr2_word%0d", i), wr_data, words_b[i]);
         tick();
      end
      wr_data_en = 1'b0;
      chk("wr2_done", wr_done, 1);

      // Bad command byte
      tick();
      send_byte(8'h05);
      chk("bad_cmd_err", frame_err, 1);
      chk("bad_cmd_idle", busy, 0);

      // Timeout after two address bytes
      send_byte(8'h01);
      send_byte(8'hAA);
      send_byte(8'hBB);
      repeat (TO - 1) tick();
      chk("timeout_not_yet", frame_err, 0);
      chk("timeout_busy", busy, 1);
      tick();
      chk("timeout_err", frame_err, 1);
      chk("timeout_idle", busy, 0);
      tick();

      // Reset during S_TX
      send_hdr(8'h02, 32'h0);
      send_byte(8'hFF);
      tick();
      rd_ack = 1'b1;
      tick();
      rd_ack = 1'b0;
      rd_data_valid = 1'b1;
      for (int i = 0; i < 4; i++) begin
         rd_data = words_b[i];
         tick();
      end
      rd_data_valid = 1'b0;
      chk("tx2_valid", tx_valid, 1);
      chk("tx2_first", tx_data, 8'h00);
      #2;
      sys_rst = 1'b1;
      #1;
      chk("async_rst_tx_valid", tx_valid, 0);
      chk("async_rst_busy", busy, 0);
      tick();
      sys_rst = 1'b0;
      tick();
      chk("post_rst_idle", busy, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
